// File: rtl/pipe_sched_pkg.sv
// pipe_sched_pkg: shared FSM states and tag-width helper for the pipeline scheduler
package pipe_sched_pkg;
  typedef enum logic {IDLE, HOLD} state_e;
  function automatic int tag_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pipe_sched_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  int k;
  always_comb begin
    idx = '0;
    found = 1'b0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      k = (k >= N) ? k - N : k;
      if (req[k[W-1:0]]) begin
        idx = W'(k);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_sched.sv
// pipe_sched: round-robin burst scheduler sharing one pipeline, with credit limit and tag-routed results
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W_DATA = 32,
  parameter int MAX_BURST = 4,
  parameter int MAX_OUT = 8,
  localparam int W_TAG = tag_w(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*W_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]        o_req_ready,
  input  logic                    i_pipe_stall,
  output logic                    o_pipe_valid,
  output logic [W_DATA-1:0]       o_pipe_data,
  output logic [W_TAG-1:0]        o_pipe_tag,
  input  logic                    i_rsp_valid,
  input  logic [W_TAG-1:0]        i_rsp_tag,
  input  logic [W_DATA-1:0]       i_rsp_data,
  output logic [N_REQ-1:0]        o_rsp_valid,
  output logic [W_DATA-1:0]       o_rsp_data,
  output logic                    o_busy
);
  localparam int W_CNT = $clog2(MAX_OUT + 1);
  localparam int W_BST = $clog2(MAX_BURST + 1);

  state_e                        state_q, state_d;
  logic [W_TAG-1:0]              owner_q, owner_d, rr_ptr_q, rr_ptr_d, eff_ptr, pick_idx, g;
  logic [W_BST-1:0]              burst_q, burst_d, burst_inc;
  logic [W_CNT-1:0]              out_cnt_q, out_cnt_d;
  logic                          pipe_valid_q, pipe_valid_d;
  logic [W_DATA-1:0]             pipe_data_q, pipe_data_d, rsp_data_q, rsp_data_d;
  logic [W_TAG-1:0]              pipe_tag_q, pipe_tag_d;
  logic [N_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic                          pick_found, in_arb, fire, burst_done;
  logic [N_REQ-1:0][W_DATA-1:0]  req_data_a;

  function automatic logic [W_TAG-1:0] nxt(input logic [W_TAG-1:0] t);
    return (int'(t) == N_REQ - 1) ? '0 : t + 1'b1;
  endfunction

  assign req_data_a = i_req_data;
  // an owner dropping valid hands over to the next requester in the same cycle
  assign in_arb = (state_q == IDLE) | ~i_req_valid[owner_q];
  assign eff_ptr = (state_q == IDLE) ? rr_ptr_q : nxt(owner_q);

  rr_pick #(.N(N_REQ), .W(W_TAG)) u_pick (
    .req  (i_req_valid),
    .ptr  (eff_ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  assign g = in_arb ? pick_idx : owner_q;
  assign fire = (in_arb ? pick_found : 1'b1) & ~i_pipe_stall & ((out_cnt_q < W_CNT'(MAX_OUT)) | i_rsp_valid);
  assign o_req_ready = fire ? N_REQ'(1) << g : '0;
  assign burst_inc = (in_arb ? '0 : burst_q) + 1'b1;
  assign burst_done = burst_inc == W_BST'(MAX_BURST);

  always_comb begin
    state_d = fire ? (burst_done ? IDLE : HOLD) : (in_arb ? IDLE : state_q);
    owner_d = fire ? g : owner_q;
    burst_d = fire ? burst_inc : burst_q;
    rr_ptr_d = fire ? (burst_done ? nxt(g) : rr_ptr_q) : (in_arb ? eff_ptr : rr_ptr_q);
    out_cnt_d = (fire & ~i_rsp_valid) ? out_cnt_q + 1'b1 :
                (~fire & i_rsp_valid & (out_cnt_q != '0)) ? out_cnt_q - 1'b1 : out_cnt_q;
    pipe_valid_d = fire;
    pipe_data_d = fire ? req_data_a[g] : pipe_data_q;
    pipe_tag_d = fire ? g : pipe_tag_q;
    rsp_valid_d = (i_rsp_valid & (int'(i_rsp_tag) < N_REQ)) ? N_REQ'(1) << i_rsp_tag : '0;
    rsp_data_d = i_rsp_valid ? i_rsp_data : rsp_data_q;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      burst_q <= '0;
      rr_ptr_q <= '0;
      out_cnt_q <= '0;
      pipe_valid_q <= 1'b0;
      pipe_data_q <= '0;
      pipe_tag_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
      rr_ptr_q <= rr_ptr_d;
      out_cnt_q <= out_cnt_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_data_q <= pipe_data_d;
      pipe_tag_q <= pipe_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign o_pipe_valid = pipe_valid_q;
  assign o_pipe_data = pipe_data_q;
  assign o_pipe_tag = pipe_tag_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data = rsp_data_q;
  assign o_busy = out_cnt_q != '0;
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: randomized and directed checks of pipe_sched against a queue-free behavioural model
module tb_pipe_sched;
  localparam int N = 4, W = 32, MB = 4, MO = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, orv;
  logic [N-1:0][W-1:0] rq = '0;
  logic [N*W-1:0] req_data;
  logic stall = 1'b0, pv, rv = 1'b0, busy;
  logic [W-1:0] pd, rd = '0, ord;
  logic [1:0] pt, rt = '0;
  logic [4:0] v5 = '0, rdy5, orv5;
  logic [159:0] d5 = '0;
  logic pv5, busy5, rv5 = 1'b0;
  logic [31:0] pd5, ord5, rd5 = '0;
  logic [2:0] pt5, rt5 = '0;

  int checks = 0, errors = 0;
  int m_owner, m_burst, m_ptr, m_cnt, m_g;
  bit m_fire;
  logic exp_pv;
  logic [W-1:0] exp_pd, exp_rd;
  logic [1:0] exp_pt;
  logic [N-1:0] exp_rv, exp_ready, last_ready, vr;
  logic [1:0] seen[$];
  logic [1:0] exp_tags[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  assign req_data = rq;
  always #5 clk = ~clk;

  pipe_sched dut (
    .i_clk(clk), .reset(reset), .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
    .i_pipe_stall(stall), .o_pipe_valid(pv), .o_pipe_data(pd), .o_pipe_tag(pt),
    .i_rsp_valid(rv), .i_rsp_tag(rt), .i_rsp_data(rd), .o_rsp_valid(orv), .o_rsp_data(ord), .o_busy(busy)
  );

  pipe_sched #(.N_REQ(5)) dut5 (
    .i_clk(clk), .reset(reset), .i_req_valid(v5), .i_req_data(d5), .o_req_ready(rdy5),
    .i_pipe_stall(1'b0), .o_pipe_valid(pv5), .o_pipe_data(pd5), .o_pipe_tag(pt5),
    .i_rsp_valid(rv5), .i_rsp_tag(rt5), .i_rsp_data(rd5), .o_rsp_valid(orv5), .o_rsp_data(ord5), .o_busy(busy5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_burst = 0; m_ptr = 0; m_cnt = 0;
    exp_pv = 1'b0; exp_pd = '0; exp_pt = '0; exp_rv = '0; exp_rd = '0;
  endtask

  // one clock: drive at negedge, check ready combinationally, update model at posedge, check registers at negedge
  task automatic step(input logic [3:0] v, input logic st, input logic r, input logic [1:0] t,
                      input logic [31:0] d, input logic rs);
    int s, k, nb;
    reset = rs; req_valid = v; stall = st; rv = r; rt = t; rd = d;
    for (int i = 0; i < N; i++) rq[i] = $urandom;
    #1;
    m_g = -1;
    if (m_owner >= 0 && v[2'(m_owner)]) m_g = m_owner;
    else begin
      s = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
      for (int i = 0; i < N; i++) begin
        k = (s + i) % N;
        if (m_g < 0 && v[2'(k)]) m_g = k;
      end
    end
    m_fire = m_g >= 0 && !st && (m_cnt < MO || r);
    exp_ready = m_fire ? 4'(1 << m_g) : 4'd0;
    last_ready = req_ready;
    chk("ready", 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    if (rs) model_reset();
    else begin
      exp_pv = m_fire;
      if (m_fire) begin
        exp_pd = rq[2'(m_g)];
        exp_pt = 2'(m_g);
        nb = ((m_g == m_owner) ? m_burst : 0) + 1;
        if (nb == MB) begin
          m_owner = -1; m_ptr = (m_g + 1) % N;
        end else begin
          m_owner = m_g; m_burst = nb;
        end
      end else if (m_owner >= 0 && !v[2'(m_owner)]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
      exp_rv = r ? 4'(1 << t) : 4'd0;
      if (r) exp_rd = d;
      if (m_fire && !r) m_cnt++;
      else if (!m_fire && r && m_cnt > 0) m_cnt--;
    end
    @(negedge clk);
    chk("pipe_valid", 64'(pv), 64'(exp_pv));
    if (exp_pv) begin
      chk("pipe_data", 64'(pd), 64'(exp_pd));
      chk("pipe_tag", 64'(pt), 64'(exp_pt));
    end
    chk("rsp_valid", 64'(orv), 64'(exp_rv));
    chk("rsp_data", 64'(ord), 64'(exp_rd));
    chk("busy", 64'(busy), 64'(m_cnt != 0));
    if (pv) seen.push_back(pt);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && m_cnt > 0; i++) step(4'd0, 1'b0, 1'b1, 2'($urandom), $urandom, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(4'd0, 0, 0, 0, 0, 1);
    step(4'd0, 0, 0, 0, 0, 1);
    chk("rst_pipe_valid", 64'(pv), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    seen.delete();
    repeat (10) step(4'hf, 0, 0, 0, 0, 0);
    chk("burst_count", 64'(seen.size()), 64'(8));
    for (int i = 0; i < 8; i++) if (i < seen.size()) chk("burst_tag", 64'(seen[i]), 64'(exp_tags[i]));
    chk("credit_block_ready", 64'(last_ready), 64'(0));
    chk("credit_busy", 64'(busy), 64'(1));
    step(4'b0010, 0, 1, 0, 0, 0);
    chk("rsp_credit_ready", 64'(last_ready), 64'(4'b0010));
    chk("rsp_strobe_t0", 64'(orv), 64'(4'b0001));
    step(4'b0010, 0, 0, 0, 0, 0);
    chk("credit_full_ready", 64'(last_ready), 64'(0));
    step(4'd0, 0, 1, 3, 32'hDEADBEEF, 0);
    chk("rsp_strobe_t3", 64'(orv), 64'(4'b1000));
    chk("rsp_data_t3", 64'(ord), 64'(32'hDEADBEEF));
    drain();
    chk("drained_busy", 64'(busy), 64'(0));
    repeat (3) step(4'b0100, 0, 0, 0, 0, 0);
    step(4'd0, 0, 0, 0, 0, 0);
    step(4'b1001, 0, 0, 0, 0, 0);
    chk("rr_after_drop", 64'(last_ready), 64'(4'b1000));
    step(4'd0, 0, 0, 0, 0, 0);
    drain();
    repeat (2) step(4'b0010, 0, 0, 0, 0, 0);
    repeat (5) begin
      step(4'b0011, 1, 0, 0, 0, 0);
      chk("stall_ready", 64'(last_ready), 64'(0));
    end
    step(4'b0011, 0, 0, 0, 0, 0);
    chk("post_stall_3", 64'(last_ready), 64'(4'b0010));
    step(4'b0011, 0, 0, 0, 0, 0);
    chk("post_stall_4", 64'(last_ready), 64'(4'b0010));
    step(4'b0011, 0, 0, 0, 0, 0);
    chk("post_burst_rotate", 64'(last_ready), 64'(4'b0001));
    step(4'd0, 0, 0, 0, 0, 0);
    drain();
    repeat (3) step(4'b0100, 0, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0, 1);
    chk("rst_mid_pipe_valid", 64'(pv), 64'(0));
    chk("rst_mid_pipe_tag", 64'(pt), 64'(0));
    chk("rst_mid_pipe_data", 64'(pd), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_rsp_valid", 64'(orv), 64'(0));
    chk("rst_mid_rsp_data", 64'(ord), 64'(0));
    step(4'd0, 0, 1, 2, 32'h1234, 0);
    chk("late_rsp_strobe", 64'(orv), 64'(4'b0100));
    chk("late_rsp_busy", 64'(busy), 64'(0));
    step(4'b1001, 0, 0, 0, 0, 0);
    chk("rst_ptr_grant", 64'(last_ready), 64'(4'b0001));
    chk("rst_one_busy", 64'(busy), 64'(1));
    step(4'd0, 0, 1, 1, 0, 0);
    chk("rst_no_wrap_busy", 64'(busy), 64'(0));
    vr = '0;
    for (int c = 0; c < 3000; c++) begin
      vr = vr ^ (4'($urandom) & 4'($urandom));
      step(vr, $urandom_range(0, 4) == 0,
           (m_cnt > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0),
           2'($urandom), $urandom, $urandom_range(0, 499) == 0);
    end
    for (int t = 0; t < 8; t++) begin
      rv5 = 1'b1; rt5 = 3'(t); rd5 = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk("rsp5_strobe", 64'(orv5), (t < 5) ? 64'(1 << t) : 64'(0));
    end
    rv5 = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
